seq_word_comparator: RTL and testbench

SEQ_WORD_COMPARATOR -- requirements
Module: seq_word_comparator

---
 rtl/seq_word_comparator.sv | 125 ++++++++++++
 tb/tb_seq_word_comparator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_word_comparator.sv
// seq_word_comparator
//   Compares two multi-word operands A and B that arrive one word pair per
//   accepted cycle, most-significant word first. The first differing word
//   decides the result. Later words are still consumed, but they cannot change
//   a result that is already decided. When SIGNED=1, the MSW is compared as
//   two's complement. All lower words are always compared as unsigned.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : begin a comparison (sampled in IDLE only)
//   in_valid  : A/B carry a valid word pair
//   A, B      : operand words, WIDTH bits
//   in_ready  : block accepts a word pair this cycle (CMP)
//   busy      : high in CMP and DONE
//   done      : one-cycle pulse, result valid
//   EQ/LT/GT  : registered result, held until the next accepted start or reset
module seq_word_comparator #(
  parameter int WIDTH  = 4,
  parameter int NWORDS = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             LT,
  output logic             GT
);

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            decided;
  logic            diff_lt;     // sign of the first differing word: 1 means A<B
  logic            word_ne;
  logic            word_lt;

  // Only the MSW is signed, and only when SIGNED is set.
  function automatic logic less_than(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic             is_msw);
    if (SIGNED != 0 && is_msw)
      return $signed(a) < $signed(b);
    else
      return a < b;
  endfunction

  assign word_ne = (A != B);
  assign word_lt = less_than(A, B, cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      decided  <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      EQ       <= 1'b0;
      LT       <= 1'b0;
      GT       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CMP;
            cnt      <= '0;
            decided  <= 1'b0;
            EQ       <= 1'b0;
            LT       <= 1'b0;
            GT       <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        CMP: begin
          if (in_valid) begin
            if (!decided && word_ne) begin
              decided <= 1'b1;
              diff_lt <= word_lt;
            end
            if (cnt == LAST) begin
              // The final word's own compare is folded into the result.
              // This makes a difference only in the last word still decide it.
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              EQ       <= !(decided || word_ne);
              LT       <= decided ? diff_lt  : (word_ne && word_lt);
              GT       <= decided ? !diff_lt : (word_ne && !word_lt);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_word_comparator.sv
module tb_seq_word_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid;
  logic [3:0] a, b;

  // Default, unsigned, NWORDS=4 instance.
  logic ready_u, busy_u, done_u, eq_u, lt_u, gt_u;
  // SIGNED=1 instance on the same stimulus.
  logic ready_s, busy_s, done_s, eq_s, lt_s, gt_s;
  // NWORDS=1 instance.
  logic       start1, valid1;
  logic [3:0] a1, b1;
  logic ready_1, busy_1, done_1, eq_1, lt_1, gt_1;

  seq_word_comparator dut_u (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .A(a), .B(b),
    .in_ready(ready_u), .busy(busy_u), .done(done_u),
    .EQ(eq_u), .LT(lt_u), .GT(gt_u));

  seq_word_comparator #(.WIDTH(4), .NWORDS(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .A(a), .B(b),
    .in_ready(ready_s), .busy(busy_s), .done(done_s),
    .EQ(eq_s), .LT(lt_s), .GT(gt_s));

  seq_word_comparator #(.WIDTH(4), .NWORDS(1), .SIGNED(0)) dut_1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(valid1), .A(a1), .B(b1),
    .in_ready(ready_1), .busy(busy_1), .done(done_1),
    .EQ(eq_1), .LT(lt_1), .GT(gt_1));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Results are packed {EQ,LT,GT}.
  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_LT = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  typedef struct {
    logic [15:0] a;      // word0 (MSW) in [15:12]
    logic [15:0] b;
    logic [2:0]  exp_u;
    logic [2:0]  exp_s;
  } vec_t;

  vec_t vecs[7];

  // Runs one 4-word comparison on the shared A/B bus. The run optionally
  // stalls before word stall_at for stall_len cycles. It can also keep start
  // high through CMP and DONE.
  task automatic run_cmp(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [2:0] eu, input logic [2:0] es,
                         input int stall_at, input int stall_len, input bit hold_start);
    logic [15:0] ta, tb_;
    ta = va; tb_ = vb;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);                       // now in CMP
    start = hold_start;
    chk({tag, "_cleared"}, {eq_u, lt_u, gt_u}, 3'b000);
    for (int w = 0; w < 4; w++) begin
      if (w == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          in_valid = 1'b0;
          @(negedge clk);
          chk({tag, "_stall_done"}, done_u, 1'b0);
          chk({tag, "_stall_ready"}, ready_u, 1'b1);
        end
      end
      chk({tag, "_ready"}, ready_u, 1'b1);
      chk({tag, "_nodone"}, done_u, 1'b0);
      a = ta[15-4*w -: 4];
      b = tb_[15-4*w -: 4];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_done"}, done_u, 1'b1);
    chk({tag, "_done_s"}, done_s, 1'b1);
    chk({tag, "_done_busy"}, busy_u, 1'b1);
    chk({tag, "_done_ready"}, ready_u, 1'b0);
    chk({tag, "_res_u"}, {eq_u, lt_u, gt_u}, eu);
    chk({tag, "_res_s"}, {eq_s, lt_s, gt_s}, es);
    @(negedge clk);                       // back in IDLE
    start = 1'b0;
    chk({tag, "_idle_done"}, done_u, 1'b0);
    chk({tag, "_idle_busy"}, busy_u, 1'b0);
    chk({tag, "_hold_u"}, {eq_u, lt_u, gt_u}, eu);
    chk({tag, "_hold_s"}, {eq_s, lt_s, gt_s}, es);
  endtask

  initial begin
    vecs[0] = '{16'h93F0, 16'h93F0, R_EQ, R_EQ};
    vecs[1] = '{16'h2500, 16'h24FF, R_GT, R_GT};
    vecs[2] = '{16'h8111, 16'h7111, R_GT, R_LT};
    vecs[3] = '{16'h0001, 16'h0002, R_LT, R_LT};
    vecs[4] = '{16'hF000, 16'h1000, R_GT, R_LT};
    vecs[5] = '{16'h123A, 16'h123B, R_LT, R_LT};
    vecs[6] = '{16'h7FFF, 16'h8000, R_LT, R_GT};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    start1 = 1'b0; valid1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {ready_u, busy_u, done_u}, 3'b000);
    chk("rst_res", {eq_u, lt_u, gt_u}, 3'b000);
    chk("rst_ctrl_1", {ready_1, busy_1, done_1}, 3'b000);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
              vecs[i].exp_u, vecs[i].exp_s, -1, 0, 1'b0);

    // Stall three cycles between words 1 and 2.
    run_cmp("stall", 16'h1234, 16'h1235, R_LT, R_LT, 2, 3, 1'b0);

    // Keep start high through CMP and DONE. The run must complete normally.
    run_cmp("hold_start", 16'h4000, 16'h3FFF, R_GT, R_GT, -1, 0, 1'b1);

    // Assert reset after two accepted words.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a = 4'h1; b = 4'h2;
    @(negedge clk);
    a = 4'h3; b = 4'h3;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", ready_u, 1'b0);
    chk("midrst_busy", busy_u, 1'b0);
    chk("midrst_res", {eq_u, lt_u, gt_u}, 3'b000);
    run_cmp("after_rst", 16'h5A5A, 16'h5A5A, R_EQ, R_EQ, -1, 0, 1'b0);

    // Single-word instance: A=3, B=5.
    @(negedge clk);
    start1 = 1'b1; valid1 = 1'b1; a1 = 4'h3; b1 = 4'h5;
    @(negedge clk);                       // CMP
    start1 = 1'b0;
    chk("n1_ready", ready_1, 1'b1);
    chk("n1_nodone", done_1, 1'b0);
    @(negedge clk);                       // DONE
    valid1 = 1'b0;
    chk("n1_done", done_1, 1'b1);
    chk("n1_res", {eq_1, lt_1, gt_1}, R_LT);
    @(negedge clk);
    chk("n1_idle", {busy_1, done_1}, 2'b00);
    chk("n1_hold", {eq_1, lt_1, gt_1}, R_LT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
